// File: rtl/logic_func_pkg.sv
// rtl/logic_func_pkg.sv - shared state type, sizes and golden model for the lab03 sweeper
package logic_func_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} sweep_state_t;

  localparam int NUM_VECTORS = 8;
  localparam int NUM_OUTPUTS = 4;

  // Returns {O4,O3,O2,O1} for input vector v = {A,B,C}
  function automatic logic [NUM_OUTPUTS-1:0] golden(input logic [2:0] v);
    logic                   a_v;
    logic                   b_v;
    logic                   c_v;
    logic [NUM_OUTPUTS-1:0] o_v;
    a_v    = v[2];
    b_v    = v[1];
    c_v    = v[0];
    o_v[0] = (a_v & c_v) | (~a_v & b_v);
    o_v[1] = (a_v | ~c_v) & b_v & c_v;
    o_v[2] = (a_v & ~b_v) | c_v;
    o_v[3] = (a_v & b_v) | (~b_v & ~c_v);
    return o_v;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable 4-bit down-counter flagging its last settle cycle
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] value_i,
  input  logic       en_i,
  output logic       last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == 4'd1);

endmodule

// File: rtl/logic_func_sweeper.sv
// rtl/logic_func_sweeper.sv - steps A/B/C through all vectors and scores logic_functions outputs
module logic_func_sweeper
  import logic_func_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic [3:0] o_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] error_count,
  output logic [7:0] fail_mask
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  sweep_state_t           state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [5:0]             err_q, err_d;
  logic [NUM_VECTORS-1:0] fm_q, fm_d;
  logic                   pass_q, pass_d;

  logic                   tmr_load;
  logic                   tmr_en;
  logic                   tmr_last;
  logic [NUM_OUTPUTS-1:0] mism;
  logic [5:0]             mism_cnt;

  settle_timer u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (SETTLE_INIT),
    .en_i    (tmr_en),
    .last_o  (tmr_last)
  );

  assign mism     = o_in ^ golden(idx_q);
  assign mism_cnt = 6'($countones(mism));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fm_d     = fm_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          err_d   = 6'd0;
          fm_d    = '0;
          pass_d  = 1'b0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_d = err_q + mism_cnt;
        if (mism != '0) begin
          fm_d = fm_q | (NUM_VECTORS'(1) << idx_q);
        end
        // idx never advances past the last vector; only a new start rewinds it
        if (idx_q == 3'(NUM_VECTORS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = APPLY;
        end
      end
      DONE: begin
        pass_d  = (err_q == 6'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      err_q   <= 6'd0;
      fm_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fm_q    <= fm_d;
      pass_q  <= pass_d;
    end
  end

  assign a           = idx_q[2];
  assign b           = idx_q[1];
  assign c           = idx_q[0];
  assign busy        = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign error_count = err_q;
  assign fail_mask   = fm_q;

endmodule

// File: tb/tb_logic_func_sweeper.sv
// tb/tb_logic_func_sweeper.sv - randomized self-checking bench for logic_func_sweeper
module tb_logic_func_sweeper;

  logic       clk;
  logic [1:0] rst_s;
  logic [1:0] start_s;
  wire  [1:0] a_s, b_s, c_s, busy_s, done_s, pass_s;
  wire  [3:0] o_s  [2];
  wire  [5:0] ec_s [2];
  wire  [7:0] fm_s [2];
  logic [3:0] xm   [2][8];

  int checks;
  int errors;

  // Truth of the lab equations, simplified by hand: O2 reduces to ABC
  function automatic logic [3:0] ref_out(input logic [2:0] v);
    logic av, bv, cv;
    av = v[2]; bv = v[1]; cv = v[0];
    return {(bv ? av : ~cv), (cv | (av & ~bv)), (av & bv & cv), (av ? cv : bv)};
  endfunction

  assign o_s[0] = ref_out({a_s[0], b_s[0], c_s[0]}) ^ xm[0][{a_s[0], b_s[0], c_s[0]}];
  assign o_s[1] = ref_out({a_s[1], b_s[1], c_s[1]}) ^ xm[1][{a_s[1], b_s[1], c_s[1]}];

  logic_func_sweeper #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .c(c_s[0]),
    .o_in(o_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .error_count(ec_s[0]), .fail_mask(fm_s[0]));

  logic_func_sweeper #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .c(c_s[1]),
    .o_in(o_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .error_count(ec_s[1]), .fail_mask(fm_s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_faults(input int k, input int kind);
    for (int v = 0; v < 8; v++) begin
      case (kind)
        0: xm[k][v] = 4'h0;
        1: xm[k][v] = ref_out(3'(v)) & 4'b0001;
        2: xm[k][v] = 4'hF;
        3: xm[k][v] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        default: xm[k][v] = 4'($urandom_range(1, 15));
      endcase
    end
  endtask

  task automatic do_sweep(input int k, input int s, input int pulse_at, input string nm,
                          output int got_ec, output logic [7:0] got_fm, output logic got_pass);
    int         exp_done, done_at, done_cnt, steps, seq_bad, busy_bad, e_ec;
    logic [7:0] e_fm;
    logic [2:0] prev, cur;
    e_ec = 0; e_fm = 8'h00;
    for (int v = 0; v < 8; v++) begin
      e_ec += $countones(xm[k][v]);
      if (xm[k][v] != 4'h0) e_fm[v] = 1'b1;
    end
    exp_done = 8 * (s + 2) + 1;
    done_at = 0; done_cnt = 0; steps = 0; seq_bad = 0; busy_bad = 0; prev = 3'd0;
    got_ec = 0; got_fm = 8'h00; got_pass = 1'b0;
    @(negedge clk); start_s[k] = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
      start_s[k] = (cyc == pulse_at);
      cur = {a_s[k], b_s[k], c_s[k]};
      if (cyc == 1 && cur != 3'd0) seq_bad++;
      if (cur != prev) begin
        if (cur != prev + 3'd1) seq_bad++;
        else steps++;
      end
      prev = cur;
      if (busy_s[k] !== (cyc < exp_done)) busy_bad++;
      if (done_s[k] === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == exp_done) begin
        got_ec = int'(ec_s[k]);
        got_fm = fm_s[k];
      end
      if (cyc == exp_done + 1) got_pass = pass_s[k];
      @(negedge clk);
    end
    start_s[k] = 1'b0;
    checks++;
    if (done_at != exp_done || done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_cycle got %0d (pulses %0d) want %0d (1 pulse)", nm, done_at, done_cnt, exp_done);
    end
    checks++;
    if (seq_bad != 0 || steps != 7) begin
      errors++;
      $display("FAIL %s abc_order got %0d steps %0d bad want 7 steps 0 bad", nm, steps, seq_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_window got %0d wrong cycles want 0", nm, busy_bad);
    end
    checks++;
    if (got_ec != e_ec || got_fm !== e_fm) begin
      errors++;
      $display("FAIL %s result got ec=%0d fm=%h want ec=%0d fm=%h", nm, got_ec, got_fm, e_ec, e_fm);
    end
    checks++;
    if (got_pass !== (e_ec == 0)) begin
      errors++;
      $display("FAIL %s pass got %b want %b", nm, got_pass, (e_ec == 0));
    end
  endtask

  task automatic test_reset;
    rst_s = 2'b11; start_s = 2'b00;
    set_faults(0, 0); set_faults(1, 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_s[k], b_s[k], c_s[k], busy_s[k], done_s[k], pass_s[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_bits k=%0d got %b want 000000", k,
                 {a_s[k], b_s[k], c_s[k], busy_s[k], done_s[k], pass_s[k]});
      end
      checks++;
      if (ec_s[k] !== 6'd0 || fm_s[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_results k=%0d got ec=%0d fm=%h want 0 00", k, ec_s[k], fm_s[k]);
      end
    end
    rst_s = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep;
    int ec; logic [7:0] fm; logic ps;
    set_faults(0, 0);
    do_sweep(0, 2, 0, "clean_s2", ec, fm, ps);
    checks++;
    if (ps !== 1'b1 || busy_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_s2_idle got pass=%b busy=%b want 1 0", ps, busy_s[0]);
    end
  endtask

  task automatic test_o1_stuck;
    int ec; logic [7:0] fm; logic ps;
    set_faults(0, 1);
    do_sweep(0, 2, 0, "o1_stuck", ec, fm, ps);
    checks++;
    if (ec != 4 || fm !== 8'hAC || ps !== 1'b0) begin
      errors++;
      $display("FAIL o1_stuck_const got ec=%0d fm=%h pass=%b want 4 ac 0", ec, fm, ps);
    end
  endtask

  task automatic test_inverted;
    int ec; logic [7:0] fm; logic ps;
    set_faults(0, 2);
    do_sweep(0, 2, 0, "inverted", ec, fm, ps);
    checks++;
    if (ec != 32 || fm !== 8'hFF || ps !== 1'b0) begin
      errors++;
      $display("FAIL inverted_const got ec=%0d fm=%h pass=%b want 32 ff 0", ec, fm, ps);
    end
  endtask

  task automatic test_random;
    int ec; logic [7:0] fm; logic ps;
    for (int r = 0; r < 4; r++) begin
      set_faults(0, 3);
      do_sweep(0, 2, 0, "random_s2", ec, fm, ps);
      set_faults(1, 3);
      do_sweep(1, 0, 0, "random_s0", ec, fm, ps);
    end
  endtask

  task automatic test_settle0;
    int ec; logic [7:0] fm; logic ps;
    set_faults(1, 0);
    do_sweep(1, 0, 10, "settle0_restart", ec, fm, ps);
    checks++;
    if (ec != 0 || ps !== 1'b1) begin
      errors++;
      $display("FAIL settle0_clean got ec=%0d pass=%b want 0 1", ec, ps);
    end
  endtask

  task automatic test_reset_mid;
    int ec; logic [7:0] fm; logic ps; int spurious;
    set_faults(0, 2);
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (ec_s[0] !== 6'd8) begin
      errors++;
      $display("FAIL mid_partial_ec got %0d want 8", ec_s[0]);
    end
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    checks++;
    if ({a_s[0], b_s[0], c_s[0], busy_s[0], done_s[0]} !== 5'b0 || ec_s[0] !== 6'd0 || fm_s[0] !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got abc=%b busy=%b done=%b ec=%0d fm=%h want 000 0 0 0 00",
               {a_s[0], b_s[0], c_s[0]}, busy_s[0], done_s[0], ec_s[0], fm_s[0]);
    end
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d active cycles want 0", spurious);
    end
    set_faults(0, 0);
    do_sweep(0, 2, 0, "after_reset", ec, fm, ps);
  endtask

  task automatic test_back_to_back;
    int         e_ec1, e_ec2, dq[$];
    logic [7:0] e_fm1, e_fm2;
    set_faults(0, 4);
    e_ec1 = 0; e_fm1 = 8'h00;
    for (int v = 0; v < 8; v++) begin
      e_ec1 += $countones(xm[0][v]);
      if (xm[0][v] != 4'h0) e_fm1[v] = 1'b1;
    end
    e_ec2 = 0; e_fm2 = 8'h00;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (done_s[0] === 1'b1) dq.push_back(cyc);
      if (cyc == 33) begin
        checks++;
        if (int'(ec_s[0]) != e_ec1 || fm_s[0] !== e_fm1) begin
          errors++;
          $display("FAIL b2b_sweep1 got ec=%0d fm=%h want %0d %h", ec_s[0], fm_s[0], e_ec1, e_fm1);
        end
        set_faults(0, 3);
        for (int v = 0; v < 8; v++) begin
          e_ec2 += $countones(xm[0][v]);
          if (xm[0][v] != 4'h0) e_fm2[v] = 1'b1;
        end
      end
      if (cyc == 35) begin
        checks++;
        if (ec_s[0] !== 6'd0 || fm_s[0] !== 8'h00 || pass_s[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_cleared got ec=%0d fm=%h pass=%b want 0 00 0", ec_s[0], fm_s[0], pass_s[0]);
        end
      end
      if (cyc == 67) begin
        checks++;
        if (int'(ec_s[0]) != e_ec2 || fm_s[0] !== e_fm2) begin
          errors++;
          $display("FAIL b2b_sweep2 got ec=%0d fm=%h want %0d %h", ec_s[0], fm_s[0], e_ec2, e_fm2);
        end
      end
      if (cyc == 68) begin
        checks++;
        if (pass_s[0] !== (e_ec2 == 0)) begin
          errors++;
          $display("FAIL b2b_pass2 got %b want %b", pass_s[0], (e_ec2 == 0));
        end
      end
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    checks++;
    if (dq.size() != 2 || dq[0] != 33 || dq[1] != 67) begin
      errors++;
      $display("FAIL b2b_done_cycles got %0d pulses first %0d want 2 pulses at 33 67",
               dq.size(), (dq.size() > 0) ? dq[0] : 0);
    end
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_sweep();
    test_o1_stuck();
    test_inverted();
    test_random();
    test_settle0();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
